spi_row_packer: RTL
===================

Name: spi_row_packer

Overview:
- Write-side counterpart of the FIFO read interface: accepts 16-bit words from the Q-SPI slave and packs them into DWIDTH-bit rows for the synchronous FIFO write port.
- Sits between the Q-SPI receive path and the `sync_fifo` `wr_en`/`wdata` ports.
- One-row holding register absorbs FIFO back-pressure. Overflow is flagged and counted, never silently merged.

Parameters:
- `DWIDTH`, 136, row width written to the FIFO.
- `WORD_W`, 16, Q-SPI word width.
- `NWORDS`, ceil(DWIDTH/WORD_W) = 9, words per row (derived, localparam).
- `CNT_W`, 8, width of the dropped-row counter.

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `wdata_spi`  in  16  word from Q-SPI
- `shift_en`  in  1  1-cycle strobe, `wdata_spi` valid
- `resync`  in  1  abandon the partial row and restart at word 0
- `fifo_full`  in  1  FIFO full flag
- `fifo_wr_en`  out  1  FIFO write strobe
- `fifo_wdata`  out  DWIDTH  row to FIFO
- `word_idx`  out  $clog2(NWORDS)  next slot to be filled
- `overflow`  out  1  sticky, a completed row was dropped
- `clr_ovf`  in  1  clears `overflow` and `drop_cnt`
- `drop_cnt`  out  CNT_W  saturating count of dropped rows

Behaviour:
- Reset (`rst`=1 at an edge): `word_idx`=0, assembly register=0, hold register=0, `hold_valid`=0, `overflow`=0, `drop_cnt`=0. Consequently `fifo_wr_en`=0 and `fifo_wdata`=0.
- Packing is LSB-first. Word k loads bits [16k+15:16k].
  - The last word (k=NWORDS-1) loads only bits [DWIDTH-1:16(NWORDS-1)].
  - Its unused upper bits are discarded (upper 8 bits for 136).
- On `shift_en`: write the word to slot `word_idx`.
  - If `word_idx` < NWORDS-1: `word_idx`++.
  - Else: the row is complete and `word_idx` goes to 0.
- Row completion, evaluated in the cycle of the last `shift_en`:
  - Hold slot is free after this cycle (`hold_valid`=0, or it drains this cycle): the full row (including the last word) loads the hold register and `hold_valid`=1 next cycle.
  - Otherwise: the row is dropped, `overflow`=1 next cycle, and `drop_cnt`++ saturating at 2^CNT_W-1.
- Hold FSM has two states.
  - EMPTY: goes to PENDING on row completion.
  - PENDING: `fifo_wr_en` = !`fifo_full` (combinational). On a write, goes to EMPTY, unless a row completes in the same cycle, in which case it stays in PENDING with the new row.
- `fifo_wdata` is always the hold register. It is stable while PENDING and `fifo_full`=1.
- Latency: last `shift_en` at cycle N gives `fifo_wr_en`=1 at N+1 (FIFO not full). Best-case throughput is one row per NWORDS cycles.
- `resync`: `word_idx`=0 and assembly register cleared. The hold register and pending write are unaffected.
  - `resync` with `shift_en` in the same cycle: the word lands in slot 0 and `word_idx`=1.
- `clr_ovf` with a drop in the same cycle: the drop wins (`overflow`=1, `drop_cnt`=1).
- `rst` mid-row or mid-pending: everything returns to reset values. The partial row and the held row are lost. No write is issued in the reset cycle.
- `shift_en` with `wdata_spi` X is not checked. There is no other gating.

Decomposition:
- `spi_fifo_pkg` holds `WORD_W`, a `calc_nwords(dwidth)` function, and the `hold_state_e` enum {`HOLD_EMPTY`, `HOLD_PENDING`}.
- The same package is shared with the read-side interface so word width and packing order agree.
- Single module, no sub-module. The hold FSM and assembly datapath are small enough to keep flat.

Test Plan:
- Basic row: after reset, 9 `shift_en` with 0x0001..0x0009 → one cycle after the 9th, `fifo_wr_en`=1 for 1 cycle and `fifo_wdata`=136'h09_0008_0007_0006_0005_0004_0003_0002_0001. `word_idx`=0.
- Back-pressure: `fifo_full`=1, send row A then 5 words of row B → `fifo_wr_en`=0 and `fifo_wdata` holds A. Drop `fifo_full` → A is written in that cycle, and row B completes and writes normally.
- Overflow: `fifo_full`=1 held, send 3 full rows → `overflow`=1 after row 2, `drop_cnt`=2, `fifo_wdata` still row 1. `clr_ovf` → both 0.
- Drain/complete collision: `fifo_full`=1, hold row A, release full in the cycle of row B's 9th word → A is written, B is loaded, no overflow, B is written next cycle.
- Resync: 4 words, then `resync` with `shift_en`(0xBEEF) in the same cycle, then 8 more words (0x0002..0x0009) → row bits[15:0]=0xBEEF and no stale data from the first 4 words.
- Reset mid-row: 5 words, then `rst`=1 for 1 cycle → `word_idx`=0, no write. A fresh 9-word row packs exactly as in the basic-row case.

Source files
------------

// File: rtl/spi_fifo_pkg.sv
// Shared Q-SPI <-> FIFO packing definitions: word width, words-per-row
// helper and the hold-slot state encoding. Used by both the write-side
// packer and the read-side unpacker so that word order always agrees.
package spi_fifo_pkg;

  localparam int WORD_W = 16;

  // Number of WORD_W words needed to cover a dwidth-bit row (rounded up).
  function automatic int calc_nwords(input int dwidth);
    return (dwidth + WORD_W - 1) / WORD_W;
  endfunction

  typedef enum logic {
    HOLD_EMPTY,
    HOLD_PENDING
  } hold_state_e;

endpackage

// File: rtl/spi_row_packer_if.sv
// Q-SPI word input and FIFO write-port signals of the row packer.
// master = the side driving words / receiving FIFO writes (SPI + FIFO glue),
// slave  = the packer itself.
interface spi_row_packer_if
  import spi_fifo_pkg::*;
#(
  parameter int DWIDTH = 136
) ();

  logic [WORD_W-1:0] wdata_spi;
  logic              shift_en;
  logic              resync;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DWIDTH-1:0] fifo_wdata;

  modport master (
    output wdata_spi, shift_en, resync, fifo_full,
    input  fifo_wr_en, fifo_wdata
  );

  modport slave (
    input  wdata_spi, shift_en, resync, fifo_full,
    output fifo_wr_en, fifo_wdata
  );

endinterface

// File: rtl/spi_row_packer.sv
// Packs 16-bit Q-SPI words LSB-first into DWIDTH-bit rows and writes them
// to the sync FIFO. A single hold register absorbs FIFO back-pressure; a
// row that completes while the hold slot is still occupied is dropped,
// flagged in the sticky overflow bit and counted (saturating).
module spi_row_packer
  import spi_fifo_pkg::*;
#(
  parameter  int DWIDTH = 136,
  parameter  int CNT_W  = 8,
  localparam int NWORDS = calc_nwords(DWIDTH),
  localparam int IDX_W  = $clog2(NWORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_row_packer_if.slave       spi,
  input  logic                  clr_ovf,
  output logic [IDX_W-1:0]      word_idx,
  output logic                  overflow,
  output logic [CNT_W-1:0]      drop_cnt
);

  // Bits of the final word that actually land in the row; the rest are dropped.
  localparam int               LAST_W   = DWIDTH - WORD_W * (NWORDS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  hold_state_e                        state_q, state_d;
  logic [IDX_W-1:0]                   word_idx_q, word_idx_d;
  // Only the first NWORDS-1 words are stored; the last word goes straight
  // into the hold register together with these.
  logic [NWORDS-2:0][WORD_W-1:0]      asm_q, asm_d;
  logic [DWIDTH-1:0]                  hold_q, hold_d;
  logic                               overflow_q, overflow_d;
  logic [CNT_W-1:0]                   drop_cnt_q, drop_cnt_d;

  logic [IDX_W-1:0]                   idx_base;
  logic [CNT_W-1:0]                   cnt_base;
  logic                               row_done;
  logic                               drain;

  // Register update; synchronous reset returns every register to zero/EMPTY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HOLD_EMPTY;
      word_idx_q <= '0;
      asm_q      <= '0;
      hold_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      asm_q      <= asm_d;
      hold_q     <= hold_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Next state: word assembly, row completion, hold FSM and drop accounting.
  always_comb begin
    // resync restarts the row before the current word is placed, so a
    // simultaneous shift_en lands in slot 0.
    idx_base   = spi.resync ? '0 : word_idx_q;
    asm_d      = spi.resync ? '0 : asm_q;
    word_idx_d = idx_base;
    row_done   = 1'b0;
    state_d    = state_q;
    hold_d     = hold_q;
    // Clear is applied first so that a drop in the same cycle still counts.
    cnt_base   = clr_ovf ? '0 : drop_cnt_q;
    overflow_d = clr_ovf ? 1'b0 : overflow_q;
    drop_cnt_d = cnt_base;
    drain      = (state_q == HOLD_PENDING) && !spi.fifo_full;

    if (spi.shift_en) begin
      if (idx_base == LAST_IDX) begin
        row_done   = 1'b1;
        word_idx_d = '0;
      end else begin
        word_idx_d = idx_base + 1'b1;
        for (int k = 0; k < NWORDS - 1; k++) begin
          if (idx_base == IDX_W'(k)) asm_d[k] = spi.wdata_spi;
        end
      end
    end

    if (row_done) begin
      // Hold slot is usable if empty now or being written to the FIFO now.
      if (state_q == HOLD_EMPTY || drain) begin
        hold_d  = {spi.wdata_spi[LAST_W-1:0], asm_q};
        state_d = HOLD_PENDING;
      end else begin
        overflow_d = 1'b1;
        drop_cnt_d = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;
      end
    end else if (drain) begin
      state_d = HOLD_EMPTY;
    end
  end

  // No write may escape during the reset cycle even if a row is pending.
  assign spi.fifo_wr_en = drain && !rst;
  assign spi.fifo_wdata = hold_q;
  assign word_idx       = word_idx_q;
  assign overflow       = overflow_q;
  assign drop_cnt       = drop_cnt_q;

endmodule
